// File: rtl/parity_up_down_counter.sv
// parity_up_down_counter
//
// Parametrised up/down counter that walks through every value, only the odd
// values, or only the even values of a WIDTH-bit range, chosen at run time.
// A synchronous load has priority over counting. At the ends of the range the
// counter either wraps or saturates, depending on SATURATE.
//
// Parameters:
//   WIDTH    counter width in bits (minimum 2)
//   SATURATE 0 = wrap at the bounds, 1 = hold at the bounds
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset (count=0, wrap=0)
//   en       count enable; a step is taken only while high
//   Y        direction: 1 = up, 0 = down
//   mode     00 = all values, 01 = odd only, 10 = even only, 11 = hold
//   load     synchronous load strobe (beats en)
//   load_val value written on load, used verbatim
//   count    registered counter value
//   tc       combinational terminal count: count is the last valid value
//            for the current mode/direction
//   wrap     registered one-cycle pulse: the previous edge wrapped
module parity_up_down_counter #(
   parameter int WIDTH    = 4,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             Y,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap
);

   typedef enum logic [1:0] {
      MODE_ALL  = 2'b00,
      MODE_ODD  = 2'b01,
      MODE_EVEN = 2'b10,
      MODE_HOLD = 2'b11
   } mode_t;

   localparam logic [WIDTH-1:0] ZERO    = '0;
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);
   localparam logic [WIDTH-1:0] MAXV    = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] MAXV_M1 = MAXV - ONE;

   mode_t            mode_sel;
   logic [WIDTH-1:0] lo_bound;
   logic [WIDTH-1:0] hi_bound;
   logic [WIDTH-1:0] step_size;
   logic             aligned;
   logic [WIDTH-1:0] next_count;
   logic             next_wrap;

   assign mode_sel = mode_t'(mode);

   // Decode the current mode into the bounds and stride of its valid set, and
   // decide whether the present count actually belongs to that set. A count
   // can be off-parity after a load or a mode change; such a count is
   // nudged by one unit on its next step instead of taking a full stride.
   always_comb begin
      lo_bound  = ZERO;
      hi_bound  = MAXV;
      step_size = ONE;
      aligned   = 1'b1;
      case (mode_sel)
         MODE_ODD: begin
            lo_bound  = ONE;
            hi_bound  = MAXV;
            step_size = TWO;
            aligned   = count[0];
         end
         MODE_EVEN: begin
            lo_bound  = ZERO;
            hi_bound  = MAXV_M1;
            step_size = TWO;
            aligned   = ~count[0];
         end
         default: begin
            lo_bound  = ZERO;
            hi_bound  = MAXV;
            step_size = ONE;
            aligned   = 1'b1;
         end
      endcase
   end

   // Next-state decision: load beats a step, a step beats holding. The
   // off-parity branch only meets a range edge in two places: count 0 going
   // down in odd mode, and count MAXV going up in even mode. Saturating there
   // means settling on the nearest valid value on the other side.
   always_comb begin
      next_count = count;
      next_wrap  = 1'b0;
      if (load) begin
         next_count = load_val;
      end else if (en && (mode_sel != MODE_HOLD)) begin
         if (aligned) begin
            if (Y) begin
               if (count == hi_bound) begin
                  if (!SATURATE) begin
                     next_count = lo_bound;
                     next_wrap  = 1'b1;
                  end
               end else begin
                  next_count = count + step_size;
               end
            end else begin
               if (count == lo_bound) begin
                  if (!SATURATE) begin
                     next_count = hi_bound;
                     next_wrap  = 1'b1;
                  end
               end else begin
                  next_count = count - step_size;
               end
            end
         end else begin
            if (!Y && (count == ZERO)) begin
               if (SATURATE) begin
                  next_count = ONE;
               end else begin
                  next_count = MAXV;
                  next_wrap  = 1'b1;
               end
            end else if (Y && (count == MAXV)) begin
               if (SATURATE) begin
                  next_count = MAXV_M1;
               end else begin
                  next_count = ZERO;
                  next_wrap  = 1'b1;
               end
            end else if (Y) begin
               next_count = count + ONE;
            end else begin
               next_count = count - ONE;
            end
         end
      end
   end

   // Terminal count is purely combinational so it reacts to a mode or
   // direction change before the next edge. It stays low for off-parity
   // counts and in hold mode.
   assign tc = (mode_sel != MODE_HOLD) && aligned &&
               (Y ? (count == hi_bound) : (count == lo_bound));

   // State register: the count and the wrap pulse both update on the edge
   // that made the decision; reset clears them without waiting for a clock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
         wrap  <= 1'b0;
      end else begin
         count <= next_count;
         wrap  <= next_wrap;
      end
   end

endmodule

// File: tb/tb_parity_up_down_counter.sv
// tb_parity_up_down_counter
//
// Drives a wrapping (SATURATE=0) and a saturating (SATURATE=1) WIDTH=4
// instance from the same stimulus. A range-based reference model predicts
// both, a compare process checks every output on each falling edge, and
// directed checks pin literal values at interesting points.
module tb_parity_up_down_counter;

   localparam int WIDTH = 4;
   localparam int MAXV  = (1 << WIDTH) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             en = 1'b0;
   logic             Y = 1'b1;
   logic [1:0]       mode = 2'b01;
   logic             load = 1'b0;
   logic [WIDTH-1:0] load_val = '0;

   logic [WIDTH-1:0] count0, count1;
   logic             tc0, tc1, wrap0, wrap1;

   int assertions = 0;
   int failures   = 0;

   int m_count [2];
   bit m_wrap  [2];
   int n_count [2];
   bit n_wrap  [2];

   parity_up_down_counter #(.WIDTH(WIDTH), .SATURATE(1'b0)) dut0 (
      .clk(clk), .reset(reset), .en(en), .Y(Y), .mode(mode), .load(load),
      .load_val(load_val), .count(count0), .tc(tc0), .wrap(wrap0)
   );

   parity_up_down_counter #(.WIDTH(WIDTH), .SATURATE(1'b1)) dut1 (
      .clk(clk), .reset(reset), .en(en), .Y(Y), .mode(mode), .load(load),
      .load_val(load_val), .count(count1), .tc(tc1), .wrap(wrap1)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial forever #5 clk = ~clk;

   // Valid set of a mode: smallest member, largest member and stride.
   function automatic void mode_limits(input int m, output int mn, output int mx, output int st);
      case (m)
         1:       begin mn = 1; mx = MAXV;     st = 2; end
         2:       begin mn = 0; mx = MAXV - 1; st = 2; end
         default: begin mn = 0; mx = MAXV;     st = 1; end
      endcase
   endfunction

   function automatic bit in_set(input int cur, input int m);
      int mn, mx, st;
      mode_limits(m, mn, mx, st);
      return ((cur - mn) % st) == 0;
   endfunction

   function automatic bit model_tc(input int cur);
      int mn, mx, st;
      if (mode == 2'b11) return 1'b0;
      if (!in_set(cur, int'(mode))) return 1'b0;
      mode_limits(int'(mode), mn, mx, st);
      return Y ? (cur == mx) : (cur == mn);
   endfunction

   // Take the intended move (a full stride, or one unit when off-parity) and
   // see whether it leaves the valid range; leaving the range either
   // saturates on the bound in the direction of travel or wraps to the
   // opposite bound.
   function automatic void model_next(input int cur, input bit sat, output int nxt, output bit nw);
      int mn, mx, st, target;
      nxt = cur;
      nw  = 1'b0;
      if (load) begin
         nxt = int'(load_val);
      end else if (en && mode != 2'b11) begin
         mode_limits(int'(mode), mn, mx, st);
         if (in_set(cur, int'(mode))) target = Y ? cur + st : cur - st;
         else                         target = Y ? cur + 1  : cur - 1;
         if (target > mx || target < mn) begin
            if (sat) begin
               nxt = Y ? mx : mn;
            end else begin
               nxt = Y ? mn : mx;
               nw  = 1'b1;
            end
         end else begin
            nxt = target;
         end
      end
   endfunction

   // Reference model state, advanced on the same edges as the DUTs.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            m_count[i] <= 0;
            m_wrap[i]  <= 1'b0;
         end
      end else begin
         model_next(m_count[0], 1'b0, n_count[0], n_wrap[0]);
         model_next(m_count[1], 1'b1, n_count[1], n_wrap[1]);
         for (int i = 0; i < 2; i++) begin
            m_count[i] <= n_count[i];
            m_wrap[i]  <= n_wrap[i];
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      assertions++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s: actual %0d, required %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Every falling edge: both DUTs against the model.
   always @(negedge clk) begin
      check("cmp_count0", int'(count0), m_count[0]);
      check("cmp_wrap0",  int'(wrap0),  int'(m_wrap[0]));
      check("cmp_tc0",    int'(tc0),    int'(model_tc(m_count[0])));
      check("cmp_count1", int'(count1), m_count[1]);
      check("cmp_wrap1",  int'(wrap1),  int'(m_wrap[1]));
      check("cmp_tc1",    int'(tc1),    int'(model_tc(m_count[1])));
   end

   task automatic applyStimulus(input bit e, input bit yy, input logic [1:0] m,
                                input bit ld, input int lv);
      en       = e;
      Y        = yy;
      mode     = m;
      load     = ld;
      load_val = WIDTH'(lv);
      @(posedge clk);
      #1;
   endtask

   // Hand-computed expectations, checked against the DUT and the model.
   task automatic checkOutput(input string name, input int idx, input int expCount,
                              input bit expWrap, input bit expTc);
      int  c;
      bit  w, t;
      c = (idx == 0) ? int'(count0) : int'(count1);
      w = (idx == 0) ? wrap0 : wrap1;
      t = (idx == 0) ? tc0 : tc1;
      check({name, "_count"}, c, expCount);
      check({name, "_wrap"}, int'(w), int'(expWrap));
      check({name, "_tc"}, int'(t), int'(expTc));
      check({name, "_model"}, m_count[idx], expCount);
   endtask

   initial begin
      // Reset state: odd mode, count 0 is off-parity so tc is low.
      #2;
      checkOutput("reset0", 0, 0, 1'b0, 1'b0);
      checkOutput("reset1", 1, 0, 1'b0, 1'b0);
      #1 reset = 1'b1;

      // Odd values going up, wrapping 15 -> 1.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1, 1, 2'b01, 0, 0);
         checkOutput("odd_up", 0, 2 * i + 1, 1'b0, (2 * i + 1) == 15);
      end
      applyStimulus(1, 1, 2'b01, 0, 0);
      checkOutput("odd_up_wrap", 0, 1, 1'b1, 1'b0);
      checkOutput("odd_up_sat", 1, 15, 1'b0, 1'b1);

      // Odd values going down from 1, wrapping 1 -> 15 twice.
      applyStimulus(1, 0, 2'b01, 0, 0);
      checkOutput("odd_dn_wrap", 0, 15, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1, 0, 2'b01, 0, 0);
         checkOutput("odd_dn", 0, 13 - 2 * i, 1'b0, (13 - 2 * i) == 1);
      end
      applyStimulus(1, 0, 2'b01, 0, 0);
      checkOutput("odd_dn_wrap2", 0, 15, 1'b1, 1'b0);

      // Even mode after loading an odd value: 7, 8, 10, 12, 14, 0, then 14.
      applyStimulus(1, 1, 2'b10, 1, 7);
      checkOutput("even_load", 0, 7, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 1, 2'b10, 0, 0);
         checkOutput("even_up", 0, 8 + 2 * i, 1'b0, (8 + 2 * i) == 14);
      end
      applyStimulus(1, 1, 2'b10, 0, 0);
      checkOutput("even_up_wrap", 0, 0, 1'b1, 1'b0);
      checkOutput("even_up_sat", 1, 14, 1'b0, 1'b1);
      applyStimulus(1, 0, 2'b10, 0, 0);
      checkOutput("even_dn_wrap", 0, 14, 1'b1, 1'b0);

      // Saturating all-values mode: 14 -> 15 and holds there.
      applyStimulus(1, 1, 2'b00, 1, 14);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 1, 2'b00, 0, 0);
         checkOutput("sat_up", 1, 15, 1'b0, 1'b1);
      end
      applyStimulus(1, 0, 2'b00, 1, 0);
      checkOutput("sat_load0", 1, 0, 1'b0, 1'b1);
      applyStimulus(1, 0, 2'b00, 0, 0);
      checkOutput("sat_dn_hold", 1, 0, 1'b0, 1'b1);
      checkOutput("all_dn_wrap", 0, 15, 1'b1, 1'b0);

      // Off-parity counts sitting on the range edge.
      applyStimulus(0, 0, 2'b01, 1, 0);
      applyStimulus(1, 0, 2'b01, 0, 0);
      checkOutput("mis_odd0_wrap", 0, 15, 1'b1, 1'b0);
      checkOutput("mis_odd0_sat", 1, 1, 1'b0, 1'b1);
      applyStimulus(1, 1, 2'b10, 1, 15);
      applyStimulus(1, 1, 2'b10, 0, 0);
      checkOutput("mis_even15_wrap", 0, 0, 1'b1, 1'b0);
      checkOutput("mis_even15_sat", 1, 14, 1'b0, 1'b1);
      applyStimulus(1, 0, 2'b01, 1, 6);
      checkOutput("mis_load6", 0, 6, 1'b0, 1'b0);
      applyStimulus(1, 0, 2'b01, 0, 0);
      checkOutput("mis_dn6", 0, 5, 1'b0, 1'b0);

      // Hold mode and disabled counting keep the value; load beats en.
      applyStimulus(1, 1, 2'b00, 1, 9);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 1, 2'b11, 0, 0);
         checkOutput("hold_mode", 0, 9, 1'b0, 1'b0);
      end
      for (int i = 0; i < 2; i++) begin
         applyStimulus(0, 0, 2'b01, 0, 0);
         checkOutput("hold_en", 0, 9, 1'b0, 1'b0);
      end
      applyStimulus(1, 1, 2'b01, 1, 3);
      checkOutput("load_wins", 0, 3, 1'b0, 1'b0);
      checkOutput("load_wins1", 1, 3, 1'b0, 1'b0);

      // Reset asserted between edges clears at once.
      applyStimulus(1, 1, 2'b00, 1, 11);
      #2 reset = 1'b0;
      #1;
      checkOutput("async_rst0", 0, 0, 1'b0, 1'b0);
      checkOutput("async_rst1", 1, 0, 1'b0, 1'b0);
      #2 reset = 1'b1;

      // Reset also clears a pending wrap pulse.
      applyStimulus(1, 1, 2'b00, 1, 15);
      applyStimulus(1, 1, 2'b00, 0, 0);
      checkOutput("pre_rst_wrap", 0, 0, 1'b1, 1'b0);
      #2 reset = 1'b0;
      #1;
      checkOutput("rst_clr_wrap", 0, 0, 1'b0, 1'b0);
      #2 reset = 1'b1;
      applyStimulus(1, 1, 2'b00, 0, 0);
      checkOutput("post_rst", 0, 1, 1'b0, 1'b0);
      applyStimulus(1, 1, 2'b00, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule

// File: doc/parity_up_down_counter.md
Name: parity_up_down_counter

Overview:
Parametrised up/down counter. Counts through all values, odd values only, or even values only, selected at run time. Supports synchronous load, count enable, wrap or saturate at the bounds, a terminal-count flag and a wrap pulse. It is the general-purpose successor to the fixed 4-bit odd up/down counter and serves as the sequence source for the lab display and test datapaths.

Parameters:
WIDTH, 4, counter width in bits (min 2); valid range 0 .. 2^WIDTH-1
SATURATE, 0, 0 = wrap at bounds, 1 = hold at bounds

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset
en  input  1  count enable; step taken only when high
Y  input  1  direction: 1 = up, 0 = down
mode  input  2  00 = all values, 01 = odd only, 10 = even only, 11 = hold
load  input  1  synchronous load strobe
load_val  input  WIDTH  value written on load
count  output  WIDTH  registered counter value
tc  output  1  combinational terminal count: count is at the last valid value for current mode/Y
wrap  output  1  registered one-cycle pulse: the previous edge wrapped

Behaviour:
- Reset (reset=0, async): count=0, wrap=0. tc follows count/mode/Y combinationally. Counting resumes on the first rising edge after reset deasserts.
- Priority per rising edge: load > (en && mode!=11) step > hold.
- load: count<=load_val verbatim, even if its parity mismatches mode. wrap<=0.
- Valid sets: MAXV = 2^WIDTH-1.
  - mode 00: min 0, max MAXV, step 1.
  - mode 01: min 1, max MAXV, step 2.
  - mode 10: min 0, max MAXV-1, step 2.
- Aligned step (count parity matches mode, or mode 00):
  - up: count+step.
  - down: count-step.
  - No carry/borrow beyond WIDTH.
- Bound crossing:
  - up at max: SATURATE=0 -> count<=min, wrap<=1. SATURATE=1 -> count unchanged, wrap<=0.
  - down at min: SATURATE=0 -> count<=max, wrap<=1. SATURATE=1 -> hold.
- Misaligned (parity mismatch after a load or mode change): the first step moves one unit toward the nearest valid value in direction Y (up: count+1, down: count-1).
  - Odd mode, count 0, down: SATURATE=0 -> MAXV with wrap=1; SATURATE=1 -> 1, wrap=0.
  - Even mode, count MAXV, up: SATURATE=0 -> 0 with wrap=1; SATURATE=1 -> MAXV-1, wrap=0.
  - All subsequent steps are aligned.
- wrap: high for exactly one cycle after a wrapping edge; cleared on any non-wrapping edge, hold, or load.
- tc:
  - 1 when Y=1 and count==max, or Y=0 and count==min, for the current mode.
  - 0 in mode 11.
  - 0 when count is misaligned.
- Changes to mode or Y take effect on the next edge. No pipeline: count updates the same edge as the decision.
- Reset asserted mid-count: immediate return to count=0, wrap=0, independent of clk.

Test Plan:
WIDTH=4, SATURATE=0, mode=01, Y=1, en=1 from reset -> count 0,1,3,5,...,15,1. wrap=1 the cycle after 15->1. tc=1 while count=15.
Same config, Y=0 from count=1 -> 15,13,...,1,15. wrap pulses after 1->15.
mode=10, load=1 load_val=7, then Y=1 -> 7,8,10,12,14,0 (wrap). Y=0 after 0 -> 14.
SATURATE=1, mode=00, Y=1 from load 14 -> 15,15,15. wrap stays 0. tc=1. Y=0 at 0 -> holds 0.
mode=11 or en=0 for 5 cycles at count=9 -> count stays 9, tc=0. Then load and en both high with load_val=3 -> count=3 (load wins).
Assert reset low between edges while count=11 -> count=0 and wrap=0 immediately, before the next clk edge.
